ram_responder: RTL and testbench
================================

# ram_responder

Byte-addressed, big-endian data/instruction memory that answers the processor's memory handshake (`mfa` request, `mfc` completion). The datapath's MAR, MDR and control-unit signals (`MemEN`, `r_w`, `dataType`) drive it. It adds a programmable number of wait states before completing each access. It replaces the zero-wait RAM behind `datapath`, so control-unit wait-for-`mfc` states are exercised.

## Interface
Parameters:
- `DEPTH`, 256: number of bytes; the storage array is named `mem[0:DEPTH-1]`, 8 bits per entry.
- `ADDR_W`, 8: address width; `DEPTH` = 2**`ADDR_W`.
- `LATENCY`, 2: wait cycles between request capture and completion; range 0–15.

Ports:
- `clk`, in, 1: the single clock; everything samples on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `mfa`, in, 1: memory function active; the initiator holds it high for the whole transaction.
- `MemEN`, in, 1: memory enable, active-low; a request is accepted only when `MemEN` = 0.
- `r_w`, in, 1: 1 = write, 0 = read.
- `dataType`, in, 2: 00 = byte, 01 = halfword, 10 = word, 11 = word (treated as 10).
- `address`, in, `ADDR_W`: byte address.
- `data_in`, in, 32: write data, right-justified for byte and halfword.
- `data_out`, out, 32: read data, zero-extended for byte and halfword.
- `mfc`, out, 1: memory function complete.

## Operation
- States are `IDLE`, `WAIT`, `DONE`.
- `IDLE`:
  - On an edge with `mfa` = 1 and `MemEN` = 0, latch `address`, `r_w`, `dataType` and `data_in`.
  - Load a 4-bit counter with `LATENCY` and go to `WAIT`.
- `WAIT`:
  - If `mfa` = 0: abort. Go to `IDLE`; no memory update; `data_out` unchanged; `mfc` stays 0.
  - Else if counter = 0: perform the access from the latched values, set `mfc` = 1, go to `DONE`.
  - Else: decrement the counter.
- `DONE`:
  - Hold `mfc` = 1 and `data_out` while `mfa` = 1.
  - When `mfa` = 0: clear `mfc` and go to `IDLE`.
  - A new request is accepted at the earliest on the edge after the return to `IDLE`.
- Addressing is big-endian: byte `a` occupies bits 31:24 of the word at `a`.
- Alignment by access size:
  - Halfword ignores `addr[0]`.
  - Word ignores `addr[1:0]`.
- Accesses by size, with `A` = the aligned latched address:
  - Word read: `data_out` = {`mem[A]`, `mem[A+1]`, `mem[A+2]`, `mem[A+3]`}.
  - Halfword read: `data_out` = {16'h0, `mem[A]`, `mem[A+1]`}.
  - Byte read: `data_out` = {24'h0, `mem[a]`}.
  - Writes store `data_in[31:0]`, `[15:0]` or `[7:0]` in the same byte order.
- Address arithmetic is modulo `DEPTH`; out-of-range addresses wrap, and `A+k` wraps as well.
- Writes never change `data_out`; `data_out` keeps the last read value.
- Input changes after capture have no effect on an in-flight access.
- `mfa` = 1 with `MemEN` = 1 in `IDLE` is ignored; `mfc` stays 0.
- Reset:
  - `mfc` = 0, `data_out` = 0, state = `IDLE`, counter = 0.
  - `mem` contents are not reset; they stay loadable hierarchically by the bench.
  - Reset mid-transaction aborts the transaction with no write.

## Timing
- A request is captured at edge E0. `mfc` and read data become valid together at edge E0 + `LATENCY` + 1.
- The write commits at that same edge.
- With `LATENCY` = 0, `mfc` rises one edge after capture.
- `mfc` falls at the first edge that samples `mfa` = 0 in `DONE`.
- Minimum back-to-back spacing is `LATENCY` + 3 edges between captures.
- `mfc` and `data_out` are registered outputs; there is no combinational path from any input.
- `reset` forces the outputs immediately, without waiting for `clk`.

## Test plan
- Word round-trip, `LATENCY` = 2:
  - Write 32'hE3A0_1005 to address 8, then read back with `dataType` = 10.
  - `mem[8..11]` = E3, A0, 10, 05.
  - `data_out` = 32'hE3A0_1005; `mfc` rises exactly 3 edges after each capture.
- Byte/halfword, starting from word 32'h1122_3344 at address 0:
  - Byte read at 2 → 32'h0000_0033.
  - Halfword read at 3 (aligned to 2) → 32'h0000_3344.
  - Byte write of 8'hAA to 1, then word read at 0 → 32'h11AA_3344.
- Abort:
  - Start a word write of 32'hDEAD_BEEF to address 4; drop `mfa` one cycle after capture.
  - `mfc` never rises; `mem[4..7]` is unchanged; the next request is accepted normally.
- Handshake hold:
  - Keep `mfa` high 5 cycles after `mfc` rises.
  - `mfc` and `data_out` stay stable; no second access occurs.
  - `mfc` falls on the edge after `mfa` drops.
  - `MemEN` = 1 with `mfa` = 1 produces no `mfc`.
- Wrap: a word write of 32'h0102_0304 to address 255 stores into `mem[252..255]` (aligned); a byte read of 256 mod `DEPTH` returns `mem[0]`.
- Reset mid-`WAIT`:
  - Assert `reset` asynchronously between edges during a write of 32'hCAFE_F00D to address 12.
  - `mfc` = 0 and `data_out` = 0 immediately.
  - `mem[12..15]` is unchanged; state = `IDLE` after release.

Source files
------------

// File: rtl/ram_responder.sv
// Byte-addressed big-endian memory behind the mfa/mfc handshake.
// Adds LATENCY wait cycles before completing each access.
module ram_responder #(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mfa,
  input  logic              MemEN,
  input  logic              r_w,
  input  logic [1:0]        dataType,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              mfc
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              mfc_q, mfc_d;
  logic              access_go;

  logic [7:0]        mem [0:DEPTH-1];

  logic [ADDR_W-1:0] base;
  logic [3:0]        lane_en;
  logic [ADDR_W-1:0] lane_addr [4];
  logic [7:0]        lane_wdata [4];
  logic [31:0]       rd_lane [4];
  logic [31:0]       rd_word;

  // dataType 11 falls into the word branch.
  always_comb begin
    base    = {addr_q[ADDR_W-1:2], 2'b00};
    lane_en = 4'b1111;
    unique case (size_q)
      2'b00: begin
        base    = addr_q;
        lane_en = 4'b0001;
      end
      2'b01: begin
        base    = {addr_q[ADDR_W-1:1], 1'b0};
        lane_en = 4'b0011;
      end
      default: ;
    endcase
  end

  // Lane gi handles byte base+gi; sh is its byte position from the LSB (big-endian).
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [1:0] sh;
      always_comb begin
        unique case (size_q)
          2'b00:   sh = 2'd0;
          2'b01:   sh = 2'(1 - gi);
          default: sh = 2'(3 - gi);
        endcase
      end
      assign lane_addr[gi]  = base + ADDR_W'(gi);
      assign lane_wdata[gi] = wdata_q[{sh, 3'b000} +: 8];
      assign rd_lane[gi]    = lane_en[gi] ? ({24'h0, mem[lane_addr[gi]]} << {sh, 3'b000}) : 32'h0;
    end
  endgenerate

  assign rd_word = rd_lane[0] | rd_lane[1] | rd_lane[2] | rd_lane[3];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    mfc_d     = mfc_q;
    access_go = 1'b0;
    unique case (state_q)
      IDLE: begin
        mfc_d = 1'b0;
        if (mfa && !MemEN) begin
          addr_d  = address;
          rw_d    = r_w;
          size_d  = dataType;
          wdata_d = data_in;
          cnt_d   = 4'(LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!mfa) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          access_go = 1'b1;
          mfc_d     = 1'b1;
          state_d   = DONE;
          if (!rw_q) rdata_d = rd_word;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (!mfa) begin
          mfc_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      rw_q    <= 1'b0;
      size_q  <= 2'b00;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      mfc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mfc_q   <= mfc_d;
    end
  end

  // Storage is never reset; an async reset forces IDLE, which suppresses any pending write.
  always_ff @(posedge clk) begin
    if (access_go && rw_q) begin
      for (int k = 0; k < 4; k++) begin
        if (lane_en[k]) mem[lane_addr[k]] <= lane_wdata[k];
      end
    end
  end

  assign data_out = rdata_q;
  assign mfc      = mfc_q;

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: word/halfword/byte accesses, abort,
// handshake hold, address wrap and asynchronous reset mid-transaction.
module tb_ram_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mfa = 1'b0;
  logic        MemEN = 1'b1;
  logic        r_w = 1'b0;
  logic [1:0]  dataType = 2'b00;
  logic [7:0]  address = 8'h00;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
  logic        mfc;

  int checks = 0;
  int errors = 0;
  logic seen;

  always #5 clk = ~clk;

  ram_responder #(.DEPTH(256), .ADDR_W(8), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .mfa(mfa), .MemEN(MemEN), .r_w(r_w),
    .dataType(dataType), .address(address), .data_in(data_in),
    .data_out(data_out), .mfc(mfc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full handshake; inputs are scrambled after capture to show they are latched.
  task automatic xact(input string tag, input logic rw, input logic [1:0] dt,
                      input logic [7:0] a, input logic [31:0] d, input int hold);
    int n;
    logic [31:0] held;
    mfa = 1'b1; MemEN = 1'b0; r_w = rw; dataType = dt; address = a; data_in = d;
    @(posedge clk); #1;
    address = ~a; data_in = ~d; dataType = ~dt; r_w = ~rw;
    n = 0;
    while (n < 20 && mfc !== 1'b1) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, " latency"}, n, 32'd3);
    held = data_out;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold mfc"}, {31'b0, mfc}, 32'd1);
      check({tag, " hold data"}, data_out, held);
    end
    mfa = 1'b0; MemEN = 1'b1;
    @(posedge clk); #1;
    check({tag, " mfc fall"}, {31'b0, mfc}, 32'd0);
  endtask

  initial begin
    #2;
    check("reset mfc", {31'b0, mfc}, 32'd0);
    check("reset data_out", data_out, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Word round-trip
    xact("wr8", 1'b1, 2'b10, 8'd8, 32'hE3A0_1005, 0);
    check("mem8..11", {dut.mem[8], dut.mem[9], dut.mem[10], dut.mem[11]}, 32'hE3A0_1005);
    xact("rd8", 1'b0, 2'b10, 8'd8, 32'h0, 0);
    check("rd8 data", data_out, 32'hE3A0_1005);

    // Byte / halfword
    xact("wr0", 1'b1, 2'b10, 8'd0, 32'h1122_3344, 0);
    xact("rdb2", 1'b0, 2'b00, 8'd2, 32'h0, 0);
    check("rdb2 data", data_out, 32'h0000_0033);
    xact("rdh3", 1'b0, 2'b01, 8'd3, 32'h0, 0);
    check("rdh3 data", data_out, 32'h0000_3344);
    xact("wrb1", 1'b1, 2'b00, 8'd1, 32'hFFFF_FFAA, 0);
    check("write keeps data_out", data_out, 32'h0000_3344);
    xact("rdw0", 1'b0, 2'b11, 8'd0, 32'h0, 0);
    check("rdw0 data", data_out, 32'h11AA_3344);

    // Abort
    xact("wr4", 1'b1, 2'b10, 8'd4, 32'h5566_7788, 0);
    mfa = 1'b1; MemEN = 1'b0; r_w = 1'b1; dataType = 2'b10; address = 8'd4; data_in = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mfa = 1'b0; MemEN = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | mfc;
    end
    check("abort no mfc", {31'b0, seen}, 32'd0);
    check("abort mem4..7", {dut.mem[4], dut.mem[5], dut.mem[6], dut.mem[7]}, 32'h5566_7788);
    xact("rd4", 1'b0, 2'b10, 8'd4, 32'h0, 0);
    check("rd4 data", data_out, 32'h5566_7788);

    // Handshake hold
    xact("hold8", 1'b0, 2'b10, 8'd8, 32'h0, 5);
    check("hold8 data", data_out, 32'hE3A0_1005);
    mfa = 1'b1; MemEN = 1'b1; r_w = 1'b0; dataType = 2'b00; address = 8'd0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      seen = seen | mfc;
    end
    check("MemEN high no mfc", {31'b0, seen}, 32'd0);
    check("MemEN high data_out", data_out, 32'hE3A0_1005);
    mfa = 1'b0;
    @(posedge clk); #1;

    // Wrap
    xact("wr255", 1'b1, 2'b10, 8'd255, 32'h0102_0304, 0);
    check("mem252..255", {dut.mem[252], dut.mem[253], dut.mem[254], dut.mem[255]}, 32'h0102_0304);
    check("mem0..3 intact", {dut.mem[0], dut.mem[1], dut.mem[2], dut.mem[3]}, 32'h11AA_3344);
    xact("rdb256", 1'b0, 2'b00, 8'(9'd256), 32'h0, 0);
    check("rdb256 data", data_out, 32'h0000_0011);
    xact("rdh255", 1'b0, 2'b01, 8'd255, 32'h0, 0);
    check("rdh255 data", data_out, 32'h0000_0304);

    // Reset mid-WAIT
    xact("wr12", 1'b1, 2'b10, 8'd12, 32'h1234_5678, 0);
    xact("rd12", 1'b0, 2'b10, 8'd12, 32'h0, 0);
    check("rd12 data", data_out, 32'h1234_5678);
    mfa = 1'b1; MemEN = 1'b0; r_w = 1'b1; dataType = 2'b10; address = 8'd12; data_in = 32'hCAFE_F00D;
    @(posedge clk); #1;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("async reset mfc", {31'b0, mfc}, 32'd0);
    check("async reset data_out", data_out, 32'h0);
    mfa = 1'b0; MemEN = 1'b1;
    @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("reset mem12..15", {dut.mem[12], dut.mem[13], dut.mem[14], dut.mem[15]}, 32'h1234_5678);
    check("reset state idle", 32'(dut.state_q), 32'd0);
    xact("rd12b", 1'b0, 2'b10, 8'd12, 32'h0, 0);
    check("rd12b data", data_out, 32'h1234_5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
